// File: rtl/cache_types_pkg.sv
// Shared cache-subsystem types: arbiter state encoding and line geometry.
package cache_types;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT_I,
    ARB_GRANT_D
  } arb_state_t;

  localparam int LINE_OFFSET_BITS = 5;
  localparam int LINE_W           = 256;

endpackage : cache_types

// File: rtl/cache_arbiter.sv
// Round-robin arbiter that serializes I-cache fills and D-cache fills/writebacks
// onto one cacheline-wide memory port. Each granted request is latched so the
// memory side sees stable values while the requesters are free to change theirs.
module cache_arbiter
  import cache_types::arb_state_t,
         cache_types::ARB_IDLE,
         cache_types::ARB_GRANT_I,
         cache_types::ARB_GRANT_D,
         cache_types::LINE_OFFSET_BITS;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  // Clears the byte-within-line offset bits of an address.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << LINE_OFFSET_BITS) - 1);

  arb_state_t        state;
  arb_state_t        state_d;
  logic              last_grant_d;   // 1 when the D side held the most recent grant
  logic              i_req;
  logic              d_req;
  logic              grant_i;
  logic              grant_d;
  logic              grant_edge;
  logic              i_done;
  logic              d_done;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              is_write_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;

  assign i_req      = i_read;
  assign d_req      = d_read | d_write;
  // On a tie the side that did not win last time goes first.
  assign grant_i    = i_req & (~d_req | last_grant_d);
  assign grant_d    = d_req & ~grant_i;
  assign grant_edge = (state == ARB_IDLE) & (grant_i | grant_d);
  assign i_done     = (state == ARB_GRANT_I) & mem_resp;
  assign d_done     = (state == ARB_GRANT_D) & mem_resp;

  // Next-state selection: grant from IDLE, return to IDLE on the memory response.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    state_d = state;
    case (state)
      ARB_IDLE: begin
        if (grant_i)      state_d = ARB_GRANT_I;
        else if (grant_d) state_d = ARB_GRANT_D;
      end
      ARB_GRANT_I,
      ARB_GRANT_D: begin
        if (mem_resp) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State register and round-robin history.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      state        <= ARB_IDLE;
      last_grant_d <= 1'b1;
    end else begin
      state <= state_d;
      if (grant_edge) last_grant_d <= grant_d;
    end
  end

  // Capture the granted request and the most recent line delivered to each side.
  always_ff @(posedge clk) begin
    // NOTE: the line-wide data registers are ordinary flops, not a memory array, so they take the reset too.
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant_edge) begin
        addr_q     <= (grant_i ? i_address : d_address) & LINE_MASK;
        is_write_q <= grant_d & d_write;
        if (grant_d & d_write) wdata_q <= d_wdata;
      end
      if (i_done) i_rdata_q <= mem_rdata;
      if (d_done) d_rdata_q <= mem_rdata;
    end
  end

  // Memory strobes from the latched request; responses steered to the granted side only.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    if (state != ARB_IDLE) begin
      mem_read    = ~is_write_q;
      mem_write   = is_write_q;
      mem_address = addr_q;
      mem_wdata   = wdata_q;
    end
    i_resp  = i_done;
    d_resp  = d_done;
    i_rdata = i_done ? mem_rdata : i_rdata_q;
    d_rdata = d_done ? mem_rdata : d_rdata_q;
  end

endmodule : cache_arbiter

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter. Expected memory transactions
// are queued when requests are raised and compared when the arbiter issues them.
module tb_cache_arbiter;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_address = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_address = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_resp = 1'b0;

  always #5 clk = ~clk;

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_address  (i_address),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_address  (d_address),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp)
  );

  typedef struct packed {
    logic              side;   // 1 = D side
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } exp_t;

  exp_t              sb[$];
  int                checks = 0;
  int                errors = 0;
  logic [LINE_W-1:0] i_last = '0;
  logic [LINE_W-1:0] d_last = '0;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic side, input logic wr, input logic [ADDR_W-1:0] addr,
                      input logic [LINE_W-1:0] data);
    exp_t e;
    e.side = side;
    e.wr   = wr;
    e.addr = addr & 32'hFFFF_FFE0;
    e.data = data;
    sb.push_back(e);
  endtask

  // Wait for the next memory strobe, compare it with the scoreboard head, hold
  // for 'latency' cycles, then answer with 'line' and check the steered response.
  task automatic serve(input int latency, input logic [LINE_W-1:0] line, input int exp_wait);
    exp_t e;
    int   waited = 0;
    while (!(mem_read | mem_write) && waited < 20) begin
      step();
      waited++;
    end
    check("strobe_seen", mem_read | mem_write, 1);
    if (!(mem_read | mem_write)) return;
    check("grant_latency", waited, exp_wait);
    check("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("mem_read", mem_read, !e.wr);
    check("mem_write", mem_write, e.wr);
    check("mem_address", mem_address, e.addr);
    if (e.wr) check("mem_wdata", mem_wdata, e.data);
    // The granted requester's inputs change; the latched copy must not.
    if (e.side) begin
      d_wdata   = ~d_wdata;
      d_address = ~d_address;
    end else begin
      i_address = ~i_address;
    end
    for (int c = 0; c < latency; c++) begin
      step();
      check("hold_read", mem_read, !e.wr);
      check("hold_write", mem_write, e.wr);
      check("hold_address", mem_address, e.addr);
      if (e.wr) check("hold_wdata", mem_wdata, e.data);
      check("no_early_resp", i_resp | d_resp, 0);
    end
    mem_rdata = line;
    mem_resp  = 1'b1;
    #1;
    check("i_resp", i_resp, !e.side);
    check("d_resp", d_resp, e.side);
    if (e.side) begin
      check("d_rdata_pass", d_rdata, line);
      check("i_rdata_held", i_rdata, i_last);
      d_last = line;
    end else begin
      check("i_rdata_pass", i_rdata, line);
      check("d_rdata_held", d_rdata, d_last);
      i_last = line;
    end
    step();
    mem_resp  = 1'b0;
    mem_rdata = {8{32'h0BAD_F00D}};
    if (e.side) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
    #1;
    check("idle_after_resp", mem_read | mem_write, 0);
    check("i_rdata_reg", i_rdata, i_last);
    check("d_rdata_reg", d_rdata, d_last);
  endtask

  initial begin
    // Reset: every output must read zero.
    step();
    step();
    rst = 1'b0;
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_i_resp", i_resp, 0);
    check("rst_d_resp", d_resp, 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);

    // Simultaneous requests straight after reset, kept continuous for six
    // transactions: I first, then strict alternation.
    i_read = 1'b1; i_address = 32'h0000_2000;
    d_read = 1'b1; d_address = 32'h0000_4000;
    push(1'b0, 1'b0, i_address, '0);
    push(1'b1, 1'b0, d_address, '0);
    for (int k = 0; k < 6; k++) begin
      serve(k % 2, {8{32'h1111_0000 + 32'(k)}}, 1);
      if (k < 4) begin
        if (k % 2 == 0) begin
          i_read = 1'b1; i_address = 32'h0000_2000 + 32'(k + 1) * 32'h40;
          push(1'b0, 1'b0, i_address, '0);
        end else begin
          d_read = 1'b1; d_address = 32'h0000_4000 + 32'(k + 1) * 32'h40;
          push(1'b1, 1'b0, d_address, '0);
        end
      end
    end

    // I-only fill of an unaligned address, memory answers after 3 cycles.
    i_read = 1'b1; i_address = 32'h0000_1044;
    push(1'b0, 1'b0, i_address, '0);
    serve(3, {32{8'hA5}}, 1);

    // D writeback whose write data changes while in flight.
    d_write = 1'b1; d_address = 32'h8000_0020; d_wdata = {8{32'h1234_5678}};
    push(1'b1, 1'b1, d_address, d_wdata);
    serve(2, {8{32'hDEAD_BEEF}}, 1);

    // Spurious memory response while idle.
    mem_rdata = {8{32'hCAFE_BABE}};
    mem_resp  = 1'b1;
    #1;
    check("spur_i_resp", i_resp, 0);
    check("spur_d_resp", d_resp, 0);
    check("spur_i_rdata", i_rdata, i_last);
    check("spur_d_rdata", d_rdata, d_last);
    step();
    mem_resp = 1'b0;
    check("spur_idle", mem_read | mem_write, 0);
    check("spur_i_rdata_reg", i_rdata, i_last);
    i_read = 1'b1; i_address = 32'h0000_0100;
    push(1'b0, 1'b0, i_address, '0);
    serve(1, {8{32'h5555_AAAA}}, 1);

    // Reset in the middle of a D fill, with an I fill pending.
    d_read = 1'b1; d_address = 32'h2000_0100;
    step();
    check("rstd_granted", mem_read, 1);
    check("rstd_address", mem_address, 32'h2000_0100);
    i_read = 1'b1; i_address = 32'h3000_0004;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstd_mem_read", mem_read, 0);
    check("rstd_mem_write", mem_write, 0);
    check("rstd_i_rdata", i_rdata, 0);
    check("rstd_d_rdata", d_rdata, 0);
    i_last = '0;
    d_last = '0;
    push(1'b0, 1'b0, i_address, '0);
    push(1'b1, 1'b0, d_address, '0);
    serve(0, {8{32'h7777_0001}}, 1);
    serve(0, {8{32'h7777_0002}}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cache_arbiter

// File: doc/cache_arbiter.md
# cache_arbiter

Arbitrates between the L1 instruction cache and L1 data cache miss/writeback traffic and serializes it onto a single cacheline-wide physical-memory port. Sits directly downstream of the two L1 caches that serve the pipeline's instruction port (address_a/read_a) and data port (address_b/read_b/write). Arbitration is round-robin on simultaneous requests. Each granted transaction's address, write data and direction are latched, and responses are steered back to the granted side only.

## Interface
Parameters:
- LINE_W, 256, cacheline width in bits
- ADDR_W, 32, address width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_read  in  1  I-cache line-fill request
- i_address  in  ADDR_W  I-cache line address; bits [4:0] ignored
- i_rdata  out  LINE_W  fill data to I-cache
- i_resp  out  1  I-side transaction complete
- d_read  in  1  D-cache line-fill request
- d_write  in  1  D-cache writeback request; d_read and d_write are never both high
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  writeback data
- d_rdata  out  LINE_W  fill data to D-cache
- d_resp  out  1  D-side transaction complete
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_W  latched line address, low 5 bits forced to 0
- mem_wdata  out  LINE_W  latched writeback data
- mem_rdata  in  LINE_W  memory read data, valid when mem_resp=1
- mem_resp  in  1  memory transaction complete, 1-cycle pulse

## Operation
- States: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - Only i_read → GRANT_I.
  - Only d_read|d_write → GRANT_D.
  - Both → grant the side not recorded in last_grant.
  - None → stay.
- On the grant edge, latch addr_q (low 5 bits zeroed), wdata_q (D writes only), is_write_q, and update last_grant.
- GRANT_x: mem_read = ~is_write_q; mem_write = is_write_q; mem_address = addr_q; mem_wdata = wdata_q. Strobes stay high until mem_resp.
- When mem_resp=1 in GRANT_x:
  - Same cycle: the granted side's resp=1, combinational passthrough of mem_resp.
  - Same cycle: the granted side's rdata = mem_rdata.
  - Next state: IDLE.
- Requesters drop their request on the edge where they see resp. IDLE therefore never re-grants a finished request.
- Non-granted side: resp=0, rdata held at last value; its request stays pending.
- Request inputs changing during GRANT_x are ignored (latched copies drive memory).
- mem_resp in IDLE is ignored: no resp is generated and no state change.
- i_rdata/d_rdata are registered copies, updated only on that side's resp cycle, and also driven combinationally during it. Between transactions they hold the last delivered line.
- Reset: state=IDLE, last_grant=D (so the first tie goes to I), addr_q=0, wdata_q=0, is_write_q=0, rdata regs=0. All outputs read 0 the cycle after reset.
- Reset mid-transaction abandons the transaction. Memory tolerates strobe withdrawal.

## Timing
- Request to memory strobe: 1 cycle (IDLE samples, GRANT drives).
- Response: 0-cycle passthrough from mem_resp to x_resp.
- Minimum occupancy per transaction: 2 cycles (grant cycle + resp cycle when memory answers immediately).
- Back-to-back: after a resp cycle there is 1 IDLE cycle before the next grant. Total turnaround is mem latency + 2 cycles.
- Starvation bound: with both sides continuously requesting, each side waits at most one other transaction.

## Structure
- Add to shared package `cache_types`: enum `arb_state_t {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D}` and localparams `LINE_OFFSET_BITS=5`, `LINE_W=256`.
- Single module with no sub-modules. The next-state logic, output decode and latch registers each go in their own always block.

## Test plan
- I-only read of 0x0000_1044, memory answers after 3 cycles with line 0xA5..A5 → mem_read one cycle after request, mem_address=0x0000_1040, i_resp pulses with i_rdata=0xA5..A5, d_resp=0.
- D writeback to 0x8000_0020 with d_wdata=0x1234..; d_wdata changed mid-transaction → mem_write=1, mem_wdata holds the original value, d_resp on mem_resp.
- Simultaneous i_read and d_read right after reset → I granted first, D granted after I completes plus 1 IDLE cycle. On the next tie, D wins.
- Continuous requests from both sides for 6 transactions → grants alternate I,D,I,D,I,D and no side waits more than one transaction.
- Spurious mem_resp in IDLE → no i_resp/d_resp and state stays IDLE.
- rst asserted during GRANT_D → next cycle mem_read=mem_write=0 and state IDLE; a pending i_read is granted the following cycle.
